uart_rx_fifo: RTL and testbench

- Downstream buffer for the UART receiver.
- Captures each received data frame on the rising edge of the receiver's done strobe and stores it in a synchronous FIFO. The host drains the FIFO with a registered read handshake.
- Tracks overrun and receiver parity-error status as sticky flags. Provides an almost-full level for RTS-style flow control.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo_if.sv | 47 ++++
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants and types shared by the UART receiver, the
//                transmitter and the receive FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Default frame format. Every UART block takes its defaults from here so
    // the receiver and the FIFO agree on the frame width.
    localparam int UART_NO_OF_BITS    = 8;
    localparam int UART_PARITY_ENABLE = 1;
    localparam int UART_STOP_BIT      = 1;

    // One data frame at the default width.
    typedef logic [UART_NO_OF_BITS-1:0] uart_data_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Connects the UART receiver and the host to the receive FIFO.
//                The slave modport is the FIFO side. The master modport is the
//                receiver/host side.
//  Signals     : rx_done_in/rx_data_in/rx_error_in  - receiver frame strobe,
//                                                     data, parity error
//                rd_en/rd_data/rd_valid             - host pop handshake
//                empty/full/almost_full/count       - occupancy status
//                overrun/rx_error/clr_flags         - sticky flags and clear
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int NO_OF_BITS = uart_pkg::UART_NO_OF_BITS,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  rx_done_in;
    logic [NO_OF_BITS-1:0] rx_data_in;
    logic                  rx_error_in;
    logic                  rd_en;
    logic [NO_OF_BITS-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [CNT_W-1:0]      count;
    logic                  overrun;
    logic                  rx_error;
    logic                  clr_flags;

    modport slave (
        input  rx_done_in, rx_data_in, rx_error_in, rd_en, clr_flags,
        output rd_data, rd_valid, empty, full, almost_full, count,
               overrun, rx_error
    );

    modport master (
        output rx_done_in, rx_data_in, rx_error_in, rd_en, clr_flags,
        input  rd_data, rd_valid, empty, full, almost_full, count,
               overrun, rx_error
    );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive buffer behind the UART receiver. It captures one
//                frame on each rising edge of rx_done_in and stores it in a
//                synchronous FIFO. The host drains the FIFO with a registered
//                pop (rd_data/rd_valid one cycle after rd_en). The module keeps
//                sticky overrun and parity-error flags and an almost-full level
//                for RTS-style flow control.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - uart_rx_fifo_if.slave (frame input, host read
//                         handshake, status and flags)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int NO_OF_BITS  = UART_NO_OF_BITS,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    uart_rx_fifo_if.slave     bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [NO_OF_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_done_q;
    logic [NO_OF_BITS-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overrun;
    logic                  r_rx_error;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_write;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // r_done_q resets high. If rx_done_in is already high when reset is
    // released, it does not look like a new frame.
    assign w_push  = bus.rx_done_in & ~r_done_q;
    assign w_pop   = bus.rd_en & ~w_empty;

    // When the FIFO is full, a simultaneous pop frees the slot that the push
    // takes. When both pointers are equal, the read sees the old word because
    // the memory write is non-blocking.
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // The storage array has no reset. Only the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= bus.rx_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q   <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_done_q   <= bus.rx_done_in;
            r_rd_valid <= w_pop;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The flags are sticky. If a set event and clr_flags occur in the same
    // cycle, the set event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun  <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_overrun  <= (r_overrun  & ~bus.clr_flags) | w_drop;
            r_rx_error <= (r_rx_error & ~bus.clr_flags) | bus.rx_error_in;
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.count       = r_count;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= CNT_W'(AFULL_LEVEL));
    assign bus.overrun     = r_overrun;
    assign bus.rx_error    = r_rx_error;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue-based reference
//                model predicts occupancy, popped data and sticky flags. The
//                bench runs directed scenarios and then a randomized run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clk;
    logic rst_n;

    uart_rx_fifo_if #(.NO_OF_BITS(UART_NO_OF_BITS), .DEPTH(DEPTH)) bus();

    uart_rx_fifo #(
        .NO_OF_BITS (UART_NO_OF_BITS),
        .DEPTH      (DEPTH),
        .AFULL_LEVEL(AFULL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    uart_data_t m_q[$];
    bit         m_prev_done;
    uart_data_t m_rd_data;
    bit         m_rd_valid;
    bit         m_overrun;
    bit         m_rx_error;
    uart_data_t last_read;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev_done = 1'b1;
        m_rd_data   = '0;
        m_rd_valid  = 1'b0;
        m_overrun   = 1'b0;
        m_rx_error  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(bus.count),       32'(m_q.size()));
        check({tag, ".empty"}, 32'(bus.empty),       32'(m_q.size() == 0));
        check({tag, ".full"},  32'(bus.full),        32'(m_q.size() == DEPTH));
        check({tag, ".afull"}, 32'(bus.almost_full), 32'(m_q.size() >= AFULL));
        check({tag, ".valid"}, 32'(bus.rd_valid),    32'(m_rd_valid));
        check({tag, ".data"},  32'(bus.rd_data),     32'(m_rd_data));
        check({tag, ".ovr"},   32'(bus.overrun),     32'(m_overrun));
        check({tag, ".rxerr"}, 32'(bus.rx_error),    32'(m_rx_error));
    endtask

    // Advance one clock with the current inputs, update the model, compare.
    task automatic step(input string tag);
        bit push, pop, ovr_set;
        push    = bus.rx_done_in && !m_prev_done;
        pop     = bus.rd_en && (m_q.size() != 0);
        ovr_set = 1'b0;
        @(posedge clk);
        #1;
        m_rd_valid = pop;
        if (pop) begin
            m_rd_data = m_q.pop_front();
            last_read = m_rd_data;
        end
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.rx_data_in);
            else                    ovr_set = 1'b1;
        end
        m_overrun   = (m_overrun  && !bus.clr_flags) || ovr_set;
        m_rx_error  = (m_rx_error && !bus.clr_flags) || bus.rx_error_in;
        m_prev_done = bus.rx_done_in;
        check_all(tag);
    endtask

    task automatic push_frame(input uart_data_t d, input string tag);
        bus.rx_done_in = 1'b1;
        bus.rx_data_in = d;
        step(tag);
        bus.rx_done_in = 1'b0;
        bus.rx_data_in = $urandom;
        step(tag);
    endtask

    task automatic idle_inputs();
        bus.rx_done_in  = 1'b0;
        bus.rx_data_in  = '0;
        bus.rx_error_in = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_flags   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".data"},  32'(bus.rd_data),     32'h0);
        check({tag, ".valid"}, 32'(bus.rd_valid),    32'h0);
        check({tag, ".count"}, 32'(bus.count),       32'h0);
        check({tag, ".empty"}, 32'(bus.empty),       32'h1);
        check({tag, ".full"},  32'(bus.full),        32'h0);
        check({tag, ".afull"}, 32'(bus.almost_full), 32'h0);
        check({tag, ".ovr"},   32'(bus.overrun),     32'h0);
        check({tag, ".rxerr"}, 32'(bus.rx_error),    32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        last_read = '0;
        #23;
        check_reset_values("reset");
        rst_n = 1'b1;
        step("idle");

        // Long done level: exactly one capture
        bus.rx_done_in = 1'b1;
        bus.rx_data_in = 8'hA5;
        for (int i = 0; i < 20; i++) step("hold");
        check("hold_count", 32'(bus.count), 32'd1);
        bus.rx_done_in = 1'b0;
        bus.rd_en = 1'b1;
        step("read1");
        bus.rd_en = 1'b0;
        check("read1_valid", 32'(bus.rd_valid), 32'd1);
        check("read1_data",  32'(bus.rd_data),  32'hA5);
        check("read1_empty", 32'(bus.empty),    32'd1);
        step("read1_after");
        check("read1_pulse", 32'(bus.rd_valid), 32'd0);

        // Fill, then overrun
        for (int i = 0; i < DEPTH; i++) begin
            push_frame(uart_data_t'(i), "fill");
            check("fill_afull", 32'(bus.almost_full), 32'(i + 1 >= AFULL));
        end
        push_frame(8'hFF, "over");
        check("over_full", 32'(bus.full),    32'd1);
        check("over_flag", 32'(bus.overrun), 32'd1);
        bus.rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step("drain");
            check("drain_data", 32'(bus.rd_data), 32'(i));
        end
        bus.rd_en = 1'b0;
        step("drain_end");
        bus.clr_flags = 1'b1;
        step("clr_ovr");
        bus.clr_flags = 1'b0;
        check("clr_ovr_flag", 32'(bus.overrun), 32'd0);

        // Full with a simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push_frame(uart_data_t'(8'h30 + i), "fill2");
        bus.rx_done_in = 1'b1;
        bus.rx_data_in = 8'h55;
        bus.rd_en      = 1'b1;
        step("pushpop");
        bus.rx_done_in = 1'b0;
        bus.rd_en      = 1'b0;
        check("pushpop_count", 32'(bus.count),   32'd16);
        check("pushpop_ovr",   32'(bus.overrun), 32'd0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step("drain2");
        bus.rd_en = 1'b0;
        check("pushpop_last", 32'(last_read), 32'h55);

        // Pops on empty
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1'b1;
            step("emptyrd");
            check("emptyrd_valid", 32'(bus.rd_valid), 32'd0);
            bus.rd_en = 1'b0;
            step("emptyrd_gap");
        end
        check("emptyrd_count", 32'(bus.count), 32'd0);

        // Parity error flag
        bus.rx_error_in = 1'b1;
        step("err_set");
        bus.rx_error_in = 1'b0;
        step("err_hold");
        check("err_held", 32'(bus.rx_error), 32'd1);
        bus.clr_flags = 1'b1;
        step("err_clr");
        check("err_cleared", 32'(bus.rx_error), 32'd0);
        bus.rx_error_in = 1'b1;
        step("err_both");
        bus.rx_error_in = 1'b0;
        bus.clr_flags   = 1'b0;
        check("err_set_wins", 32'(bus.rx_error), 32'd1);
        bus.clr_flags = 1'b1;
        step("err_clr2");
        bus.clr_flags = 1'b0;

        // Async reset during a rd_valid pulse
        for (int i = 0; i < 5; i++) push_frame(uart_data_t'($urandom), "pre_rst");
        bus.rd_en = 1'b1;
        step("rst_pop");
        bus.rd_en = 1'b0;
        bus.rx_done_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midrst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst");
        check("post_rst_count", 32'(bus.count), 32'd0);
        bus.rx_done_in = 1'b0;
        step("post_rst_low");

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) bus.rx_done_in = ~bus.rx_done_in;
            bus.rx_data_in  = $urandom;
            bus.rd_en       = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70));
            bus.rx_error_in = ($urandom_range(0, 31) == 0);
            bus.clr_flags   = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
